regfile_sb: RTL and testbench
=============================

// Module: regfile_sb
// PURPOSE
//  Scoreboarded, multi-read-port MIPS register file for the pipelined core. NUM_RD
//  combinational read ports, one write-back port, optional write-through bypass and
//  hardwired zero register. Per-register pending bits let decode stall on RAW/WAW
//  hazards against in-flight producers.
// PARAMETERS
//  ADDR_SIZE  5   register address width; 2**ADDR_SIZE registers
//  WORD_SIZE  32  data width
//  NUM_RD     2   number of read ports (>=1)
//  ZERO_REG   1   1: register 0 reads 0, ignores writes, never pending
//  BYPASS     1   1: same-cycle write-back data forwarded to reads
// PORTS
//  clk_i          in   1                   clock, rising edge
//  rst_ni         in   1                   async reset, active low
//  rs_addr_i      in   NUM_RD*ADDR_SIZE    read addresses; port k = [k*ADDR_SIZE +: ADDR_SIZE]
//  rs_data_o      out  NUM_RD*WORD_SIZE    read data, same packing
//  rs_busy_o      out  NUM_RD              read register has pending producer
//  issue_valid_i  in   1                   decode issues instr writing issue_rd_i
//  issue_rd_i     in   ADDR_SIZE           destination of issued instr
//  issue_ready_o  out  1                   issue accepted this cycle when high with valid
//  wb_en_i        in   1                   write-back enable
//  wb_rd_i        in   ADDR_SIZE           write-back address
//  wb_data_i      in   WORD_SIZE           write-back data
//  flush_i        in   1                   clear all pending bits (pipeline flush)
//  busy_vec_o     out  2**ADDR_SIZE        registered pending bits, debug/trace
// BEHAVIOUR
//  Reset (rst_ni low, async): all registers = 0, all pending = 0; busy_vec_o = 0;
//   rs_data_o = 0, rs_busy_o = 0, issue_ready_o = 1 while in reset (rs_* after reset
//   follow the read rules below). Writes/issues during reset ignored.
//  Write: on posedge, wb_en_i=1 -> ram[wb_rd_i] <= wb_data_i; 1-cycle latency to array.
//   ZERO_REG=1 and wb_rd_i=0 -> write dropped.
//  Read (combinational, per port k): addr=0 with ZERO_REG -> 0; else if BYPASS and
//   wb_en_i and wb_rd_i==addr -> wb_data_i; else ram[addr].
//  Pending bit p[r]:
//   - flush_i: all p <= 0 next edge; overrides issue and write-back same cycle.
//   - else set when issue_valid_i & issue_ready_o (r=issue_rd_i, r!=0 if ZERO_REG).
//   - else clear when wb_en_i & wb_rd_i==r.
//   - set and clear same r same cycle -> set wins (new producer).
//  issue_ready_o = ~p[issue_rd_i] | (wb_en_i & wb_rd_i==issue_rd_i)
//   | (ZERO_REG & issue_rd_i==0). Blocks WAW; independent of issue_valid_i and flush_i.
//  rs_busy_o[k] = p[addr_k] & ~(BYPASS & wb_en_i & wb_rd_i==addr_k); 0 for reg 0 when
//   ZERO_REG. Without BYPASS, reader stalls one extra cycle after write-back.
//  Write-back to non-pending register legal: data written, p unchanged (stays 0).
//  All address arithmetic unsigned, no wrap; NUM_RD ports fully independent, any may
//   alias the same register.
// TESTING
//  1 reset; wb r5=0xDEADBEEF; next cycle rs_addr port0=5 -> rs_data 0xDEADBEEF, busy 0.
//  2 wb r7=0x12345678 with port1 addr=7 same cycle -> BYPASS=1: 0x12345678; BYPASS=0:
//    old value 0, new value next cycle.
//  3 wb r0=0xFFFFFFFF, issue r0 -> read r0 = 0, busy_vec_o[0]=0, issue_ready_o=1.
//  4 issue r3 -> busy_vec_o[3]=1, rs_busy(3)=1; issue r3 again -> issue_ready_o=0;
//    wb r3=0x55 + issue r3 same cycle -> accepted, p[3] stays 1, ram[3]=0x55.
//  5 issue r4, r9 pending; flush_i with issue r10 -> next cycle busy_vec_o=0, r10 not set.
//  6 r2=0xA5, p[6]=1; drop rst_ni between edges -> immediately busy_vec_o=0, r2 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - scoreboarded multi-read-port register file with write-back bypass
//
// Purpose: register array for the pipelined core. NUM_RD combinational read
// ports, one write-back port, optional same-cycle bypass and hardwired zero
// register. A pending bit per register tracks in-flight producers so decode
// can stall on RAW (rs_busy_o) and WAW (issue_ready_o) hazards.
//
// Ports:
//   clk_i, rst_ni     clock (rising edge), asynchronous active-low reset
//   rs_addr_i         NUM_RD packed read addresses, port k at [k*ADDR_SIZE +: ADDR_SIZE]
//   rs_data_o         NUM_RD packed read data, same packing
//   rs_busy_o         per-port: addressed register still has a pending producer
//   issue_valid_i     decode issues an instruction writing issue_rd_i
//   issue_rd_i        destination register of the issued instruction
//   issue_ready_o     issue is accepted when high together with issue_valid_i
//   wb_en_i, wb_rd_i, wb_data_i   write-back port
//   flush_i           clear every pending bit
//   busy_vec_o        registered pending bits for debug/trace

module regfile_sb #(
    parameter int ADDR_SIZE = 5,
    parameter int WORD_SIZE = 32,
    parameter int NUM_RD    = 2,
    parameter int ZERO_REG  = 1,
    parameter int BYPASS    = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [NUM_RD*ADDR_SIZE-1:0]   rs_addr_i,
    output logic [NUM_RD*WORD_SIZE-1:0]   rs_data_o,
    output logic [NUM_RD-1:0]             rs_busy_o,
    input  logic                          issue_valid_i,
    input  logic [ADDR_SIZE-1:0]          issue_rd_i,
    output logic                          issue_ready_o,
    input  logic                          wb_en_i,
    input  logic [ADDR_SIZE-1:0]          wb_rd_i,
    input  logic [WORD_SIZE-1:0]          wb_data_i,
    input  logic                          flush_i,
    output logic [(1<<ADDR_SIZE)-1:0]     busy_vec_o
);

    localparam int NREG = 1 << ADDR_SIZE;
    localparam bit ZR   = (ZERO_REG != 0);
    localparam bit BP   = (BYPASS != 0);

    logic [WORD_SIZE-1:0] r_ram [NREG];
    logic [NREG-1:0]      r_pend;
    logic [NREG-1:0]      w_pend_next;

    logic w_wb_write;
    logic w_issue_zero;
    logic w_wb_hits_issue;
    logic w_issue_ready;
    logic w_issue_fire;

    assign w_wb_write      = wb_en_i & ~(ZR & (wb_rd_i == '0));
    assign w_issue_zero    = ZR & (issue_rd_i == '0);
    assign w_wb_hits_issue = wb_en_i & (wb_rd_i == issue_rd_i);

    // A pending destination may be re-issued in the same cycle its producer
    // writes back; the new issue then becomes the owner of the pending bit.
    assign w_issue_ready   = ~r_pend[issue_rd_i] | w_wb_hits_issue | w_issue_zero;
    assign w_issue_fire    = issue_valid_i & w_issue_ready & ~w_issue_zero;

    // r_pend is forced to zero during reset, so this is already 1 there.
    assign issue_ready_o   = w_issue_ready;
    assign busy_vec_o      = r_pend;

    // Clear before set so that a same-register issue wins over write-back.
    always_comb begin
        w_pend_next = r_pend;
        if (flush_i) begin
            w_pend_next = '0;
        end else begin
            if (wb_en_i) begin
                w_pend_next[wb_rd_i] = 1'b0;
            end
            if (w_issue_fire) begin
                w_pend_next[issue_rd_i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NREG; i++) begin
                r_ram[i] <= '0;
            end
        end else if (w_wb_write) begin
            r_ram[wb_rd_i] <= wb_data_i;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_SIZE-1:0] w_addr;
        logic                 w_zero;
        logic                 w_hit;

        assign w_addr = rs_addr_i[k*ADDR_SIZE +: ADDR_SIZE];
        assign w_zero = ZR & (w_addr == '0);
        assign w_hit  = BP & wb_en_i & (wb_rd_i == w_addr);

        // Outputs are held at zero while in reset so the bypass path cannot
        // leak write-back data before the array is live.
        assign rs_data_o[k*WORD_SIZE +: WORD_SIZE] =
            (!rst_ni || w_zero) ? '0 :
            w_hit               ? wb_data_i :
                                  r_ram[w_addr];

        assign rs_busy_o[k] = rst_ni & ~w_zero & r_pend[w_addr] & ~w_hit;
    end

endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - self-checking bench for regfile_sb

module tb_regfile_sb;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;
    localparam int NREG = 1 << AW;

    logic                clk;
    logic                rst_n;
    logic [NR*AW-1:0]    rs_addr;
    logic [NR*DW-1:0]    rs_data;
    logic [NR-1:0]       rs_busy;
    logic                issue_valid;
    logic [AW-1:0]       issue_rd;
    logic                issue_ready;
    logic                wb_en;
    logic [AW-1:0]       wb_rd;
    logic [DW-1:0]       wb_data;
    logic                flush;
    logic [NREG-1:0]     busy_vec;

    int n_checks = 0;
    int n_errors = 0;

    regfile_sb #(
        .ADDR_SIZE(AW), .WORD_SIZE(DW), .NUM_RD(NR), .ZERO_REG(1), .BYPASS(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rs_addr_i(rs_addr), .rs_data_o(rs_data), .rs_busy_o(rs_busy),
        .issue_valid_i(issue_valid), .issue_rd_i(issue_rd), .issue_ready_o(issue_ready),
        .wb_en_i(wb_en), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
        .flush_i(flush), .busy_vec_o(busy_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
        end
    endtask

    // Architectural model: register contents and pending set.
    logic [DW-1:0] m_ram  [NREG];
    bit            m_pend [NREG];

    function automatic bit model_ready();
        if (issue_rd == 0) return 1'b1;
        if (wb_en && wb_rd == issue_rd) return 1'b1;
        return !m_pend[issue_rd];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                m_ram[i]  = '0;
                m_pend[i] = 1'b0;
            end
        end else begin
            bit rdy;
            rdy = model_ready();
            if (flush) begin
                for (int i = 0; i < NREG; i++) m_pend[i] = 1'b0;
            end else begin
                if (wb_en) m_pend[wb_rd] = 1'b0;
                if (issue_valid && rdy && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            end
            if (wb_en && wb_rd != 0) m_ram[wb_rd] = wb_data;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        logic [NREG-1:0] exp_vec;
        for (int i = 0; i < NREG; i++) exp_vec[i] = m_pend[i];
        for (int k = 0; k < NR; k++) begin
            logic [AW-1:0] a;
            logic [DW-1:0] ed;
            logic          eb;
            a = rs_addr[k*AW +: AW];
            if (!rst_n || a == 0)               ed = '0;
            else if (wb_en && wb_rd == a)       ed = wb_data;
            else                                ed = m_ram[a];
            eb = rst_n && a != 0 && m_pend[a] && !(wb_en && wb_rd == a);
            check($sformatf("model_rs_data%0d", k), 64'(rs_data[k*DW +: DW]), 64'(ed));
            check($sformatf("model_rs_busy%0d", k), 64'(rs_busy[k]), 64'(eb));
        end
        check("model_issue_ready", 64'(issue_ready), 64'(model_ready()));
        check("model_busy_vec", 64'(busy_vec), 64'(exp_vec));
    end

    task automatic idle();
        issue_valid = 0; issue_rd = '0; wb_en = 0; wb_rd = '0; wb_data = '0; flush = 0;
    endtask

    // Advance to just after the next rising edge; new inputs follow.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rs(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rs_addr = {a1, a0};
    endtask

    initial begin
        rst_n = 0;
        idle();
        set_rs(5'd5, 5'd5);
        // Activity during reset: must be ignored and outputs held at reset values.
        wb_en = 1; wb_rd = 5'd5; wb_data = 32'hCAFE_F00D;
        issue_valid = 1; issue_rd = 5'd5;
        #3;
        check("rst_rs_data", 64'(rs_data), 64'h0);
        check("rst_rs_busy", 64'(rs_busy), 64'h0);
        check("rst_issue_ready", 64'(issue_ready), 64'h1);
        check("rst_busy_vec", 64'(busy_vec), 64'h0);
        @(negedge clk); @(negedge clk);
        idle();
        #2 rst_n = 1;

        // 1: write r5, read next cycle
        cyc();
        wb_en = 1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF; set_rs(5'd5, 5'd0);
        cyc();
        idle();
        #2;
        check("t1_read_r5", 64'(rs_data[DW-1:0]), 64'hDEAD_BEEF);
        check("t1_busy_r5", 64'(rs_busy[0]), 64'h0);

        // 2: bypass on port1
        cyc();
        wb_en = 1; wb_rd = 5'd7; wb_data = 32'h1234_5678; set_rs(5'd5, 5'd7);
        #2;
        check("t2_bypass_r7", 64'(rs_data[2*DW-1:DW]), 64'h1234_5678);
        cyc();
        idle();
        #2;
        check("t2_array_r7", 64'(rs_data[2*DW-1:DW]), 64'h1234_5678);

        // 3: zero register ignores writes and issues
        cyc();
        wb_en = 1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        issue_valid = 1; issue_rd = 5'd0; set_rs(5'd0, 5'd0);
        #2;
        check("t3_r0_read", 64'(rs_data[DW-1:0]), 64'h0);
        check("t3_r0_ready", 64'(issue_ready), 64'h1);
        cyc();
        idle();
        #2;
        check("t3_r0_after", 64'(rs_data[DW-1:0]), 64'h0);
        check("t3_r0_pend", 64'(busy_vec[0]), 64'h0);

        // 4: WAW blocking and same-cycle re-issue
        cyc();
        issue_valid = 1; issue_rd = 5'd3; set_rs(5'd3, 5'd3);
        cyc();
        #2;
        check("t4_pend3", 64'(busy_vec[3]), 64'h1);
        check("t4_rs_busy", 64'(rs_busy), 64'h3);
        check("t4_waw_block", 64'(issue_ready), 64'h0);
        cyc();
        wb_en = 1; wb_rd = 5'd3; wb_data = 32'h55;
        #2;
        check("t4_reissue_ready", 64'(issue_ready), 64'h1);
        check("t4_bypass_busy", 64'(rs_busy), 64'h0);
        cyc();
        idle();
        #2;
        check("t4_pend3_kept", 64'(busy_vec[3]), 64'h1);
        check("t4_ram3", 64'(rs_data[DW-1:0]), 64'h55);
        cyc();
        wb_en = 1; wb_rd = 5'd3; wb_data = 32'h66;
        cyc();
        idle();
        #2;
        check("t4_pend3_cleared", 64'(busy_vec[3]), 64'h0);
        check("t4_ram3_new", 64'(rs_data[2*DW-1:DW]), 64'h66);

        // 5: flush overrides a same-cycle issue
        cyc();
        issue_valid = 1; issue_rd = 5'd4;
        cyc();
        issue_rd = 5'd9;
        cyc();
        issue_rd = 5'd10; flush = 1;
        #2;
        check("t5_pend_before", 64'(busy_vec), 64'h0000_0210);
        cyc();
        idle();
        #2;
        check("t5_flushed", 64'(busy_vec), 64'h0);

        // 6: asynchronous reset mid-cycle
        cyc();
        wb_en = 1; wb_rd = 5'd2; wb_data = 32'hA5; issue_valid = 1; issue_rd = 5'd6;
        set_rs(5'd2, 5'd6);
        cyc();
        idle();
        #2;
        check("t6_r2", 64'(rs_data[DW-1:0]), 64'hA5);
        check("t6_pend6", 64'(busy_vec[6]), 64'h1);
        rst_n = 0;
        #1;
        check("t6_rst_vec", 64'(busy_vec), 64'h0);
        check("t6_rst_r2", 64'(rs_data[DW-1:0]), 64'h0);
        @(negedge clk);
        #2 rst_n = 1;
        cyc();
        #2;
        check("t6_r2_cleared", 64'(rs_data[DW-1:0]), 64'h0);
        cyc();
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
